// File: rtl/nbody_pkg.sv
// Shared constants for the n-body force engine: pipeline latencies, scheduler
// state codes and the register-block select codes.
package nbody_pkg;

  localparam int BODY_ADDR_WIDTH = 9;

  localparam int MULT_TIME     = 11;
  localparam int ADD_TIME      = 20;
  localparam int INVSQRT_TIME  = 27;
  localparam int FORCE_LATENCY = 2 * ADD_TIME + 4 * MULT_TIME + INVSQRT_TIME;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_FORCE  = 2'd1;
  localparam state_t S_DRAIN  = 2'd2;
  localparam state_t S_UPDATE = 2'd3;

  localparam logic [3:0] GO       = 4'd0;
  localparam logic [3:0] READ     = 4'd1;
  localparam logic [3:0] N_BODIES = 4'd2;
  localparam logic [3:0] X_SEL    = 4'd3;
  localparam logic [3:0] Y_SEL    = 4'd4;
  localparam logic [3:0] VX_SEL   = 4'd5;
  localparam logic [3:0] VY_SEL   = 4'd6;
  localparam logic [3:0] M_SEL    = 4'd7;
  localparam logic [3:0] GAP      = 4'd8;
  localparam logic [3:0] DONE     = 4'd9;
  localparam logic [3:0] READ_X   = 4'd10;
  localparam logic [3:0] READ_Y   = 4'd11;

endpackage

// File: rtl/nbody_pair_counter.sv
// Ordered (i, j) pair walker with self-skip; registers hold the pair currently
// presented to the force pipeline and read as zero when idle.
module nbody_pair_counter #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          advance,
  input  logic          stop,
  input  logic [AW:0]   n,
  output logic [AW-1:0] i,
  output logic [AW-1:0] j,
  output logic          first,
  output logic          last,
  output logic          wrap
);

  logic [AW:0] ni;
  logic [AW:0] nj;

  function automatic logic is_first(input logic [AW:0] fi, input logic [AW:0] fj);
    logic [AW:0] lo;
    lo = (fi == '0) ? (AW+1)'(1) : '0;
    return fj == lo;
  endfunction

  function automatic logic is_last(input logic [AW:0] fi, input logic [AW:0] fj,
                                   input logic [AW:0] fn);
    logic [AW:0] hi;
    hi = (fi == fn - 1'b1) ? fn - 2'd2 : fn - 1'b1;
    return fj == hi;
  endfunction

  // Next pair: a row ends on its last j, otherwise step j and hop over i.
  always_comb begin
    ni = {1'b0, i};
    nj = {1'b0, j} + 1'b1;
    if (last) begin
      ni = {1'b0, i} + 1'b1;
      nj = '0;
    end else if (nj == {1'b0, i}) begin
      nj = {1'b0, j} + 2'd2;
    end
  end

  assign wrap = last && ({1'b0, i} == n - 1'b1);

  always_ff @(posedge clk) begin
    if (rst || stop) begin
      i     <= '0;
      j     <= '0;
      first <= 1'b0;
      last  <= 1'b0;
    end else if (start) begin
      i     <= '0;
      j     <= AW'(1);
      first <= 1'b1;
      last  <= is_last('0, (AW+1)'(1), n);
    end else if (advance) begin
      i     <= ni[AW-1:0];
      j     <= nj[AW-1:0];
      first <= is_first(ni, nj);
      last  <= is_last(ni, nj, n);
    end
  end

endmodule

// File: rtl/nbody_pair_scheduler.sv
// Step sequencer for the n-body engine: force pairs, pipeline drain, then the
// per-body update sweep, flipping the ping-pong bank after every step.
module nbody_pair_scheduler
  import nbody_pkg::*;
#(
  parameter int BODY_ADDR_WIDTH = nbody_pkg::BODY_ADDR_WIDTH,
  parameter int LATENCY         = FORCE_LATENCY,
  parameter int STEP_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [BODY_ADDR_WIDTH:0]   n_bodies,
  input  logic [STEP_WIDTH-1:0]      steps,
  output logic                       busy,
  output logic                       done,
  output logic                       pair_valid,
  output logic [BODY_ADDR_WIDTH-1:0] pair_i,
  output logic [BODY_ADDR_WIDTH-1:0] pair_j,
  output logic                       pair_first,
  output logic                       pair_last,
  output logic                       upd_valid,
  output logic [BODY_ADDR_WIDTH-1:0] upd_idx,
  output logic                       bank_sel,
  output logic [STEP_WIDTH-1:0]      step_cnt
);

  localparam int DW = $clog2(LATENCY + 1);
  localparam logic [BODY_ADDR_WIDTH:0] N_MAX = {1'b1, {BODY_ADDR_WIDTH{1'b0}}};

  state_t                    state;
  logic [BODY_ADDR_WIDTH:0]  n_lat;
  logic [BODY_ADDR_WIDTH:0]  n_clamped;
  logic [BODY_ADDR_WIDTH:0]  cnt_n;
  logic [STEP_WIDTH-1:0]     steps_lat;
  logic [DW-1:0]             drain_cnt;
  logic                      go_ok;
  logic                      last_upd;
  logic                      final_step;
  logic                      cnt_start;
  logic                      cnt_advance;
  logic                      cnt_stop;
  logic                      cnt_wrap;

  assign n_clamped  = (n_bodies > N_MAX) ? N_MAX : n_bodies;
  assign go_ok      = go && (n_clamped > (BODY_ADDR_WIDTH+1)'(1)) && (steps != '0);
  assign cnt_n      = (state == S_IDLE) ? n_clamped : n_lat;
  assign last_upd   = ({1'b0, upd_idx} == n_lat - 1'b1);
  assign final_step = (step_cnt + 1'b1) == steps_lat;
  assign busy       = (state != S_IDLE);

  // The counter is loaded on the same edge that raises pair_valid so both agree.
  always_comb begin
    cnt_start   = 1'b0;
    cnt_advance = 1'b0;
    cnt_stop    = 1'b0;
    case (state)
      S_IDLE:   cnt_start = go_ok;
      S_FORCE:  begin
        if (cnt_wrap) cnt_stop = 1'b1;
        else          cnt_advance = 1'b1;
      end
      S_UPDATE: cnt_start = last_upd && !final_step;
      default:  ;
    endcase
  end

  nbody_pair_counter #(
    .AW(BODY_ADDR_WIDTH)
  ) u_pair_counter (
    .clk     (clk),
    .rst     (rst),
    .start   (cnt_start),
    .advance (cnt_advance),
    .stop    (cnt_stop),
    .n       (cnt_n),
    .i       (pair_i),
    .j       (pair_j),
    .first   (pair_first),
    .last    (pair_last),
    .wrap    (cnt_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      n_lat      <= '0;
      steps_lat  <= '0;
      drain_cnt  <= '0;
      done       <= 1'b0;
      pair_valid <= 1'b0;
      upd_valid  <= 1'b0;
      upd_idx    <= '0;
      bank_sel   <= 1'b0;
      step_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go_ok) begin
            state      <= S_FORCE;
            n_lat      <= n_clamped;
            steps_lat  <= steps;
            done       <= 1'b0;
            step_cnt   <= '0;
            pair_valid <= 1'b1;
          end else if (go) begin
            done <= 1'b1;
          end
        end
        S_FORCE: begin
          if (cnt_wrap) begin
            state      <= S_DRAIN;
            pair_valid <= 1'b0;
            drain_cnt  <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(LATENCY - 1)) begin
            state     <= S_UPDATE;
            upd_valid <= 1'b1;
            upd_idx   <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          if (last_upd) begin
            upd_valid <= 1'b0;
            upd_idx   <= '0;
            bank_sel  <= ~bank_sel;
            step_cnt  <= step_cnt + 1'b1;
            if (final_step) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              state      <= S_FORCE;
              pair_valid <= 1'b1;
            end
          end else begin
            upd_idx <= upd_idx + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbody_pair_scheduler.sv
// Bench for nbody_pair_scheduler: a cycle-by-cycle expected trace is built from
// nested loops over bodies and steps, plus hand-computed done times per run.
module tb_nbody_pair_scheduler;

  localparam int AW   = 5;
  localparam int LAT  = 122;
  localparam int SW   = 32;
  localparam int MAXN = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [AW:0]   n_bodies;
  logic [SW-1:0] steps;
  logic          busy;
  logic          done;
  logic          pair_valid;
  logic [AW-1:0] pair_i;
  logic [AW-1:0] pair_j;
  logic          pair_first;
  logic          pair_last;
  logic          upd_valid;
  logic [AW-1:0] upd_idx;
  logic          bank_sel;
  logic [SW-1:0] step_cnt;

  nbody_pair_scheduler #(
    .BODY_ADDR_WIDTH (AW),
    .LATENCY         (LAT),
    .STEP_WIDTH      (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .n_bodies   (n_bodies),
    .steps      (steps),
    .busy       (busy),
    .done       (done),
    .pair_valid (pair_valid),
    .pair_i     (pair_i),
    .pair_j     (pair_j),
    .pair_first (pair_first),
    .pair_last  (pair_last),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .bank_sel   (bank_sel),
    .step_cnt   (step_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          pv;
    logic [AW-1:0] pi;
    logic [AW-1:0] pj;
    logic          pf;
    logic          pl;
    logic          uv;
    logic [AW-1:0] ui;
    logic          bank;
    logic [SW-1:0] step;
  } out_t;

  typedef struct {
    int n;
    int steps;
    int done_at;
    int bank;
    int step;
  } vec_t;

  out_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   m_bank     = 0;
  int   m_step     = 0;
  int   self_pairs = 0;
  int   last_pair  = 0;

  function automatic out_t sampleDut();
    out_t s;
    s.busy = busy;       s.done = done;      s.pv = pair_valid;
    s.pi   = pair_i;     s.pj   = pair_j;    s.pf = pair_first;
    s.pl   = pair_last;  s.uv   = upd_valid; s.ui = upd_idx;
    s.bank = bank_sel;   s.step = step_cnt;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected outputs for every cycle from k+1 to the cycle done is seen.
  task automatic buildTrace(input int n_req, input int st);
    int   n;
    int   k;
    out_t r;
    exp_q.delete();
    n = (n_req > MAXN) ? MAXN : n_req;
    if (n < 2 || st == 0) begin
      r = '0; r.done = 1'b1; r.bank = m_bank[0]; r.step = SW'(m_step);
      exp_q.push_back(r);
      return;
    end
    m_step = 0;
    for (int s = 0; s < st; s++) begin
      for (int i = 0; i < n; i++) begin
        k = 0;
        for (int j = 0; j < n; j++) begin
          if (j == i) continue;
          r = '0; r.busy = 1'b1; r.pv = 1'b1; r.pi = AW'(i); r.pj = AW'(j);
          r.pf = (k == 0); r.pl = (k == n - 2);
          r.bank = m_bank[0]; r.step = SW'(m_step);
          exp_q.push_back(r);
          k++;
        end
      end
      for (int d = 0; d < LAT; d++) begin
        r = '0; r.busy = 1'b1; r.bank = m_bank[0]; r.step = SW'(m_step);
        exp_q.push_back(r);
      end
      for (int u = 0; u < n; u++) begin
        r = '0; r.busy = 1'b1; r.uv = 1'b1; r.ui = AW'(u);
        r.bank = m_bank[0]; r.step = SW'(m_step);
        exp_q.push_back(r);
      end
      m_bank ^= 1;
      m_step++;
    end
    r = '0; r.done = 1'b1; r.bank = m_bank[0]; r.step = SW'(m_step);
    exp_q.push_back(r);
  endtask

  task automatic applyStimulus(input int n, input int st);
    n_bodies = (AW+1)'(n);
    steps    = SW'(st);
    go       = 1'b1;
    @(posedge clk);
    #1;
    go       = 1'b0;
    n_bodies = (AW+1)'($urandom);
    steps    = SW'($urandom);
  endtask

  task automatic doReset();
    rst = 1'b1;
    go  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_bank = 0;
    m_step = 0;
  endtask

  // Walks the expected trace; optionally pulses a stray go at trace index inj_at.
  task automatic runCheck(input string tag, input int inj_at, input int inj_n,
                          output int done_idx, output out_t last_act);
    out_t act;
    out_t fa;
    out_t fe;
    logic bad;
    bad        = 1'b0;
    done_idx   = -1;
    self_pairs = 0;
    last_pair  = -1;
    fa = '0; fe = '0; act = '0;
    for (int idx = 0; idx < exp_q.size(); idx++) begin
      @(negedge clk);
      if (idx == inj_at + 1) go = 1'b0;
      act = sampleDut();
      if (done_idx < 0 && act.done) done_idx = idx;
      if (act.pv) begin
        if (act.pi == act.pj) self_pairs++;
        last_pair = (int'(act.pi) << 8) | int'(act.pj);
      end
      if (!bad && act !== exp_q[idx]) begin
        bad = 1'b1; fa = act; fe = exp_q[idx];
        $display("[TB] %s first divergence at trace index %0d", tag, idx);
      end
      if (idx == inj_at) begin
        go = 1'b1; n_bodies = (AW+1)'(inj_n); steps = SW'(7);
      end
    end
    if (!bad) begin
      fa = act; fe = exp_q[exp_q.size() - 1];
    end
    checkOutput({tag, "_trace"}, 64'(fa), 64'(fe));
    last_act = act;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   done_idx;
    out_t last_act;
    int   rn;
    int   rs;
    int   gap;

    vecs[0] = '{n: 3,  steps: 1, done_at: 131,  bank: 1, step: 1};
    vecs[1] = '{n: 21, steps: 2, done_at: 1126, bank: 0, step: 2};
    vecs[2] = '{n: 2,  steps: 3, done_at: 378,  bank: 1, step: 3};
    vecs[3] = '{n: 1,  steps: 1, done_at: 0,    bank: 0, step: 0};
    vecs[4] = '{n: 5,  steps: 0, done_at: 0,    bank: 0, step: 0};
    vecs[5] = '{n: 0,  steps: 4, done_at: 0,    bank: 0, step: 0};
    vecs[6] = '{n: 4,  steps: 1, done_at: 138,  bank: 1, step: 1};

    rst = 1'b1; go = 1'b0; n_bodies = '0; steps = '0;
    doReset();
    @(negedge clk);
    checkOutput("reset_state", 64'(sampleDut()), 64'(0));

    for (int t = 0; t < 7; t++) begin
      doReset();
      @(negedge clk);
      buildTrace(vecs[t].n, vecs[t].steps);
      applyStimulus(vecs[t].n, vecs[t].steps);
      runCheck($sformatf("vec%0d", t), -10, 0, done_idx, last_act);
      checkOutput($sformatf("vec%0d_done_at", t), 64'(done_idx), 64'(vecs[t].done_at));
      checkOutput($sformatf("vec%0d_bank", t), 64'(last_act.bank), 64'(vecs[t].bank));
      checkOutput($sformatf("vec%0d_step_cnt", t), 64'(last_act.step), 64'(vecs[t].step));
      checkOutput($sformatf("vec%0d_busy_end", t), 64'(last_act.busy), 64'(0));
    end

    // Stray go during DRAIN with a different body count.
    doReset();
    @(negedge clk);
    buildTrace(3, 1);
    applyStimulus(3, 1);
    runCheck("busy_go", 10, 5, done_idx, last_act);
    checkOutput("busy_go_done_at", 64'(done_idx), 64'(131));
    checkOutput("busy_go_step_cnt", 64'(last_act.step), 64'(1));

    // Reset while pair (1,0) is on the outputs, then a clean restart.
    doReset();
    @(negedge clk);
    applyStimulus(3, 1);
    repeat (3) @(negedge clk);
    checkOutput("rst_at_pair", 64'((int'(pair_i) << 8) | int'(pair_j)), 64'(256));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_bank = 0;
    m_step = 0;
    @(negedge clk);
    checkOutput("rst_outputs", 64'(sampleDut()), 64'(0));
    buildTrace(3, 1);
    applyStimulus(3, 1);
    runCheck("restart", -10, 0, done_idx, last_act);
    checkOutput("restart_done_at", 64'(done_idx), 64'(131));

    // Oversized body count clamps to the maximum.
    doReset();
    @(negedge clk);
    buildTrace(40, 1);
    applyStimulus(40, 1);
    runCheck("clamp", -10, 0, done_idx, last_act);
    checkOutput("clamp_done_at", 64'(done_idx), 64'(MAXN * (MAXN - 1) + LAT + MAXN));
    checkOutput("clamp_self_pairs", 64'(self_pairs), 64'(0));
    checkOutput("clamp_last_pair", 64'(last_pair), 64'(((MAXN - 1) << 8) | (MAXN - 2)));

    // Random back-to-back runs, including go on the done cycle.
    for (int r = 0; r < 8; r++) begin
      rn  = $urandom_range(0, 12);
      rs  = $urandom_range(0, 3);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      buildTrace(rn, rs);
      applyStimulus(rn, rs);
      runCheck($sformatf("rand%0d_n%0d_s%0d", r, rn, rs), -10, 0, done_idx, last_act);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
